// File: rtl/alu_sequencer_if.sv
// Memory and ALU bus shared by the sequencer (master) and its memory/ALU (slave).
// The sequencer drives addresses, write data and operands; the slave returns read data and ALU results.
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int OP_W   = 4
);
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  modport master (
    output mem_we, mem_re, mem_addr, mem_wdata, alu_a, alu_b, alu_op,
    input  mem_rdata, alu_result, alu_carry
  );

  modport slave (
    input  mem_we, mem_re, mem_addr, mem_wdata, alu_a, alu_b, alu_op,
    output mem_rdata, alu_result, alu_carry
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetches two operands from memory, runs them through an external ALU and
// optionally writes the result back, one operation per accepted start.
module alu_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int OP_W      = 4,
  parameter int WRITEBACK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a_addr,
  input  logic [ADDR_W-1:0] src_b_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [OP_W-1:0]   op_in,
  alu_sequencer_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, LATCH_A, FETCH_B, LATCH_B, EXEC, WRITE, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] a_addr_reg, b_addr_reg, dst_addr_reg;
  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] opa_reg, opb_reg, result_reg;
  logic              carry_reg;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Request fields are captured only on acceptance, so later input changes cannot disturb a running op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_addr_reg   <= '0;
      b_addr_reg   <= '0;
      dst_addr_reg <= '0;
      op_reg       <= '0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_addr_reg   <= src_a_addr;
            b_addr_reg   <= src_b_addr;
            dst_addr_reg <= dst_addr;
            op_reg       <= op_in;
          end
        end
        LATCH_A: opa_reg <= bus.mem_rdata;
        LATCH_B: opb_reg <= bus.mem_rdata;
        EXEC: begin
          result_reg <= bus.alu_result;
          carry_reg  <= bus.alu_carry;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done       = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH_A;
      FETCH_A: begin
        mem_re     = 1'b1;
        mem_addr   = a_addr_reg;
        state_next = LATCH_A;
      end
      LATCH_A: state_next = FETCH_B;
      FETCH_B: begin
        mem_re     = 1'b1;
        mem_addr   = b_addr_reg;
        state_next = LATCH_B;
      end
      LATCH_B: state_next = EXEC;
      EXEC:    state_next = (WRITEBACK != 0) ? WRITE : DONE;
      WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = dst_addr_reg;
        mem_wdata  = result_reg;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.alu_a     = opa_reg;
  assign bus.alu_b     = opb_reg;
  assign bus.alu_op    = op_reg;

  assign busy   = (state_reg != IDLE);
  assign result = result_reg;
  assign carry  = carry_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: two sequencers (write-back on and off) against a byte memory and a small ALU model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [11:0] src_a_addr, src_b_addr, dst_addr;
  logic [3:0]  op_in;
  logic        busy0, done0, carry0, busy1, done1, carry1;
  logic [7:0]  result0, result1;

  logic        pl_we;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  mem0 [4096];
  logic [7:0]  mem1 [4096];
  logic [7:0]  rdata0, rdata1;

  int err_cnt = 0;
  int chk_cnt = 0;
  int done_cnt0 = 0, we_cnt0 = 0, we_cnt1 = 0;
  int base_we, base_done, n;

  int t_re   [7] = '{1, 0, 1, 0, 0, 0, 0};
  int t_we   [7] = '{0, 0, 0, 0, 0, 1, 0};
  int t_addr [7] = '{0, 0, 'h800, 0, 0, 1, 0};
  int t_wd   [7] = '{0, 0, 0, 0, 0, 3, 0};
  int t_done [7] = '{0, 0, 0, 0, 0, 0, 1};

  alu_sequencer_if #(.DATA_W(8), .ADDR_W(12), .OP_W(4)) bus0 ();
  alu_sequencer_if #(.DATA_W(8), .ADDR_W(12), .OP_W(4)) bus1 ();

  alu_sequencer #(.DATA_W(8), .ADDR_W(12), .OP_W(4), .WRITEBACK(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr), .dst_addr(dst_addr), .op_in(op_in),
    .bus(bus0.master), .busy(busy0), .done(done0), .result(result0), .carry(carry0)
  );

  alu_sequencer #(.DATA_W(8), .ADDR_W(12), .OP_W(4), .WRITEBACK(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr), .dst_addr(dst_addr), .op_in(op_in),
    .bus(bus1.master), .busy(busy1), .done(done1), .result(result1), .carry(carry1)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h2:    return {1'b0, a & b};
      4'h4:    return {1'b0, a ^ b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign {bus0.alu_carry, bus0.alu_result} = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b);
  assign {bus1.alu_carry, bus1.alu_result} = alu_f(bus1.alu_op, bus1.alu_a, bus1.alu_b);
  assign bus0.mem_rdata = rdata0;
  assign bus1.mem_rdata = rdata1;

  always @(posedge clk) begin
    if (pl_we) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end
    if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    if (bus0.mem_re) rdata0 <= mem0[bus0.mem_addr];
    if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus1.mem_re) rdata1 <= mem1[bus1.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bus rules watched on every cycle of every scenario.
  always @(negedge clk) begin
    check("we_re_excl0", 32'(bus0.mem_we & bus0.mem_re), 0);
    check("we_re_excl1", 32'(bus1.mem_we & bus1.mem_re), 0);
    check("done_busy0", 32'(done0 & ~busy0), 0);
    check("done_busy1", 32'(done1 & ~busy1), 0);
    if (done0) done_cnt0++;
    if (bus0.mem_we) we_cnt0++;
    if (bus1.mem_we) we_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic run_op0(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] d, input logic [3:0] op,
                         input logic [7:0] exp_res, input logic exp_c, input bit scramble);
    int cyc;
    src_a_addr = a;
    src_b_addr = b;
    dst_addr   = d;
    op_in      = op;
    start0     = 1'b1;
    tick();
    start0     = 1'b0;
    if (scramble) begin
      src_a_addr = 12'h800;
      src_b_addr = 12'h010;
      dst_addr   = 12'h7FF;
      op_in      = 4'h4;
    end
    cyc = 1;
    while (!done0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, 7);
    check({tag, "_res"}, 32'(result0), 32'(exp_res));
    check({tag, "_carry"}, 32'(carry0), 32'(exp_c));
    tick();
    check({tag, "_idle"}, 32'(busy0), 0);
    check({tag, "_mem"}, 32'(mem0[d]), 32'(exp_res));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    src_a_addr = '0; src_b_addr = '0; dst_addr = '0; op_in = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_result", 32'(result0), 0);
    check("rst_carry", 32'(carry0), 0);
    check("rst_we", 32'(bus0.mem_we), 0);
    check("rst_re", 32'(bus0.mem_re), 0);
    check("rst_addr", 32'(bus0.mem_addr), 0);
    check("rst_alu_a", 32'(bus0.alu_a), 0);
    check("rst_alu_op", 32'(bus0.alu_op), 0);
    reset = 1'b1;
    tick();

    preload(12'h000, 8'h01); preload(12'h800, 8'h02); preload(12'h001, 8'h77);
    preload(12'h002, 8'h77); preload(12'h005, 8'hEE); preload(12'h010, 8'hFF);
    preload(12'h011, 8'h01); preload(12'h020, 8'hAA); preload(12'h030, 8'h55);
    preload(12'h040, 8'hF0); preload(12'h041, 8'h3C);

    // Cycle-by-cycle walk of 0x01 + 0x02 -> mem[0x001].
    src_a_addr = 12'h000; src_b_addr = 12'h800; dst_addr = 12'h001; op_in = 4'h0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("seq_re_c%0d", c), 32'(bus0.mem_re), t_re[c-1]);
      check($sformatf("seq_we_c%0d", c), 32'(bus0.mem_we), t_we[c-1]);
      check($sformatf("seq_addr_c%0d", c), 32'(bus0.mem_addr), t_addr[c-1]);
      check($sformatf("seq_wdata_c%0d", c), 32'(bus0.mem_wdata), t_wd[c-1]);
      check($sformatf("seq_done_c%0d", c), 32'(done0), t_done[c-1]);
      check($sformatf("seq_busy_c%0d", c), 32'(busy0), 1);
      if (c == 5) begin
        check("seq_alu_a", 32'(bus0.alu_a), 1);
        check("seq_alu_b", 32'(bus0.alu_b), 2);
      end
      if (c < 7) tick();
    end
    check("seq_result", 32'(result0), 3);
    check("seq_carry", 32'(carry0), 0);
    tick();
    check("seq_idle", 32'(busy0), 0);
    check("seq_mem", 32'(mem0[12'h001]), 3);

    run_op0("ovf", 12'h010, 12'h011, 12'h020, 4'h0, 8'h00, 1'b1, 1'b0);
    run_op0("same_addr", 12'h030, 12'h030, 12'h031, 4'h0, 8'hAA, 1'b0, 1'b1);
    run_op0("and", 12'h040, 12'h041, 12'h042, 4'h2, 8'h30, 1'b0, 1'b0);
    run_op0("xor", 12'h040, 12'h041, 12'h043, 4'h4, 8'hCC, 1'b0, 1'b0);

    // Start held high: the second op may only begin from IDLE.
    src_a_addr = 12'h000; src_b_addr = 12'h800; dst_addr = 12'h002; op_in = 4'h0;
    base_done = done_cnt0;
    start0 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 7) check("hold_done_c7", 32'(done0), 1);
      if (c == 8) check("hold_idle_c8", 32'(busy0), 0);
    end
    check("hold_one_done", done_cnt0 - base_done, 1);
    start0 = 1'b0;
    n = 14;
    while (!done0 && n < 30) begin
      tick();
      n++;
    end
    check("hold_second_done", n, 15);
    check("hold_mem", 32'(mem0[12'h002]), 3);
    tick();

    // Reset during FETCH_B aborts without a write or done pulse.
    base_we = we_cnt0;
    base_done = done_cnt0;
    src_a_addr = 12'h000; src_b_addr = 12'h800; dst_addr = 12'h005; op_in = 4'h0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    check("abort_in_fetch_b", 32'(bus0.mem_re), 1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy0), 0);
    check("abort_re", 32'(bus0.mem_re), 0);
    check("abort_result", 32'(result0), 0);
    check("abort_carry", 32'(carry0), 0);
    check("abort_alu_a", 32'(bus0.alu_a), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_no_we", we_cnt0 - base_we, 0);
    check("abort_no_done", done_cnt0 - base_done, 0);
    check("abort_mem", 32'(mem0[12'h005]), 32'h0EE);
    run_op0("after_abort", 12'h000, 12'h800, 12'h005, 4'h0, 8'h03, 1'b0, 1'b0);

    // Write-back disabled: done one cycle earlier and memory untouched.
    src_a_addr = 12'h000; src_b_addr = 12'h800; dst_addr = 12'h001; op_in = 4'h0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 20) begin
      tick();
      n++;
    end
    check("nowb_lat", n, 6);
    check("nowb_result", 32'(result1), 3);
    check("nowb_carry", 32'(carry1), 0);
    tick();
    check("nowb_idle", 32'(busy1), 0);
    check("nowb_no_we", we_cnt1, 0);
    check("nowb_mem", 32'(mem1[12'h001]), 32'h077);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, memory data and ALU operand width.
REQ-002 Parameter ADDR_W, default 12, memory address width.
REQ-003 Parameter OP_W, default 4, ALU opcode width.
REQ-004 Parameter WRITEBACK, default 1, 1 = store result to memory, 0 = skip store.
REQ-005 clk  input  1  single clock, rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request one operation; sampled only in IDLE.
REQ-008 src_a_addr  input  ADDR_W  operand A address.
REQ-009 src_b_addr  input  ADDR_W  operand B address.
REQ-010 dst_addr  input  ADDR_W  result address.
REQ-011 op_in  input  OP_W  ALU opcode for this operation.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_re  output  1  memory read enable.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_re.
REQ-017 alu_a, alu_b  output  DATA_W  ALU operands.
REQ-018 alu_op  output  OP_W  ALU opcode.
REQ-019 alu_result  input  DATA_W  combinational ALU result.
REQ-020 alu_carry  input  1  combinational ALU carry out.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle completion pulse.
REQ-023 result  output  DATA_W  last captured ALU result, held until next EXEC.
REQ-024 carry  output  1  last captured carry, held until next EXEC.

Function
REQ-025 States: IDLE, FETCH_A, LATCH_A, FETCH_B, LATCH_B, EXEC, WRITE, DONE; register-based FSM.
REQ-026 IDLE: start=1 at an edge latches src_a_addr, src_b_addr, dst_addr, op_in and moves to FETCH_A; otherwise stays.
REQ-027 FETCH_A: mem_re=1, mem_addr=latched A address; next LATCH_A.
REQ-028 LATCH_A: mem_re=0; mem_rdata captured into operand A register at end of cycle; next FETCH_B.
REQ-029 FETCH_B/LATCH_B: identical to A using latched B address, into operand B register; next EXEC.
REQ-030 alu_a, alu_b, alu_op driven continuously from operand and opcode registers.
REQ-031 EXEC: alu_result and alu_carry captured into result and carry at end of cycle; next WRITE if WRITEBACK=1, else DONE.
REQ-032 WRITE: mem_we=1, mem_addr=latched dst_addr, mem_wdata=result register; next DONE.
REQ-033 DONE: done=1 for exactly this cycle; next IDLE unconditionally.
REQ-034 Latency: start sampled at edge 0 -> done high during cycle 7 (WRITEBACK=1) or cycle 6 (WRITEBACK=0).
REQ-035 start while busy=1 (including DONE) is ignored; no queueing.
REQ-036 mem_we and mem_re never high in the same cycle; both low in IDLE, LATCH_x, EXEC, DONE.
REQ-037 mem_addr and mem_wdata are 0 in states not driving them.
REQ-038 src_a_addr == src_b_addr is legal; two independent reads occur.
REQ-039 Input address/opcode changes after start is accepted have no effect on the running operation.

Reset
REQ-040 reset low forces IDLE immediately; mem_we, mem_re, busy, done, carry = 0; result, operand, address and opcode registers = 0.
REQ-041 reset mid-operation aborts it: no memory write issued, no done pulse; next start after release runs a full operation normally.

Verification
REQ-042 mem[0x000]=0x01, mem[0x800]=0x02, op 0000 (add), dst 0x001, start -> done in cycle 7, result=0x03, carry=0, mem[0x001]=0x03.
REQ-043 mem[0x010]=0xFF, mem[0x011]=0x01, add -> result=0x00, carry=1, mem[dst]=0x00.
REQ-044 start held high through entire operation -> exactly one done per accepted start; second operation begins only from IDLE.
REQ-045 reset pulsed low during FETCH_B -> mem_we never asserted, done never pulses, outputs zero; subsequent start completes correctly.
REQ-046 WRITEBACK=0, same operands as REQ-042 -> mem_we never high, done in cycle 6, result=0x03.
REQ-047 Checker throughout all scenarios: never mem_we and mem_re both high; busy low iff IDLE.
